// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - branch request/resolution handshake between fetch and branch_unit
interface branch_unit_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] cond;
  logic [7:0] imm8;
  logic       taken;
  logic       done;

  modport master (
    output req_valid, cond, imm8,
    input  req_ready, taken, done
  );

  modport slave (
    input  req_valid, cond, imm8,
    output req_ready, taken, done
  );
endinterface

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - status register, program counter and three-state branch resolver
module branch_unit #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            status_load,
  input  logic [2:0]      Z_in,
  input  logic            pc_inc,
  branch_unit_if.slave    bus,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      status
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    WRITE
  } state_t;

  state_t     state;
  logic [2:0] cond_q;
  logic [7:0] imm_q;
  logic       taken_q;

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_target;

  assign pc_seq    = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_target = pc_seq + {{(PC_W-8){imm_q[7]}}, imm_q};

  // status bits: [0]=Z, [1]=N, [2]=V; reserved codes never branch
  function automatic logic decide(input logic [2:0] c, input logic [2:0] s);
    logic t;
    case (c)
      3'b000:  t = 1'b1;
      3'b001:  t = s[0];
      3'b010:  t = ~s[0];
      3'b011:  t = s[1] ^ s[2];
      3'b100:  t = (s[1] ^ s[2]) | s[0];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      status        <= 3'b000;
      cond_q        <= 3'b000;
      imm_q         <= 8'h00;
      taken_q       <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.taken     <= 1'b0;
    end else begin
      if (status_load) begin
        status <= Z_in;
      end
      bus.done  <= 1'b0;
      bus.taken <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cond_q        <= bus.cond;
            imm_q         <= bus.imm8;
            bus.req_ready <= 1'b0;
            state         <= EVAL;
          end else if (pc_inc) begin
            pc <= pc_seq;
          end
        end
        EVAL: begin
          // decision uses the register value before any load on this edge
          taken_q <= decide(cond_q, status);
          state   <= WRITE;
        end
        WRITE: begin
          pc            <= taken_q ? pc_target : pc_seq;
          bus.done      <= 1'b1;
          bus.taken     <= taken_q;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard bench for branch_unit
module tb_branch_unit;
  localparam int PC_W = 9;
  localparam int PC_MOD = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            status_load;
  logic [2:0]      Z_in;
  logic            pc_inc;
  logic [PC_W-1:0] pc;
  logic [2:0]      status;

  always #5 clk = ~clk;

  branch_unit_if bus();

  branch_unit #(.PC_W(PC_W), .RESET_PC(9'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .status_load (status_load),
    .Z_in        (Z_in),
    .pc_inc      (pc_inc),
    .bus         (bus),
    .pc          (pc),
    .status      (status)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [PC_W-1:0] m_pc;
  logic [2:0]      m_status;
  logic [PC_W:0]   sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic m_taken(input logic [2:0] c, input logic [2:0] s);
    logic z, n, v;
    z = s[0]; n = s[1]; v = s[2];
    if (c == 3'd0) return 1'b1;
    if (c == 3'd1) return z;
    if (c == 3'd2) return !z;
    if (c == 3'd3) return n != v;
    if (c == 3'd4) return (n != v) || z;
    return 1'b0;
  endfunction

  function automatic logic [PC_W-1:0] m_next(input logic t, input logic [7:0] imm, input logic [PC_W-1:0] p);
    int v;
    v = int'(p) + 1 + (t ? int'($signed(imm)) : 0);
    v = ((v % PC_MOD) + PC_MOD) % PC_MOD;
    return v[PC_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic [2:0] c, input logic [7:0] imm, input int mode, input logic [2:0] hz);
    logic [2:0]      s_eff;
    logic            t;
    logic [PC_W-1:0] np;
    check("pc_before_req", pc, m_pc);
    check("ready_idle", bus.req_ready, 1);
    s_eff = (mode == 1) ? hz : m_status;
    t  = m_taken(c, s_eff);
    np = m_next(t, imm, m_pc);
    sb_q.push_back({t, np});
    m_pc = np;
    bus.req_valid = 1'b1;
    bus.cond      = c;
    bus.imm8      = imm;
    if (mode == 1) begin
      status_load = 1'b1;
      Z_in        = hz;
    end
    tick();
    bus.req_valid = 1'b0;
    status_load   = 1'b0;
    if (mode == 1) m_status = hz;
    check("ready_busy", bus.req_ready, 0);
  endtask

  task automatic wait_done(input int exp_edges, input bit post);
    int cnt;
    logic [PC_W:0] e;
    cnt = 0;
    while (!bus.done && cnt < 8) begin
      tick();
      cnt++;
    end
    check("done_seen", bus.done, 1);
    check("latency", cnt, exp_edges);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("taken", bus.taken, e[PC_W]);
      check("pc_after", pc, e[PC_W-1:0]);
    end
    if (post) begin
      tick();
      check("done_pulse", bus.done, 0);
      check("taken_pulse", bus.taken, 0);
    end
  endtask

  task automatic branch(input logic [2:0] c, input logic [7:0] imm, input int mode, input logic [2:0] hz);
    accept_req(c, imm, mode, hz);
    if (mode == 2) begin
      status_load = 1'b1;
      Z_in        = hz;
      tick();
      status_load = 1'b0;
      m_status    = hz;
      wait_done(1, 1'b1);
    end else begin
      wait_done(2, 1'b1);
    end
  endtask

  task automatic do_load(input logic [2:0] z);
    status_load = 1'b1;
    Z_in        = z;
    tick();
    status_load = 1'b0;
    m_status    = z;
    check("status_load", status, z);
  endtask

  task automatic do_inc(input int n);
    pc_inc = 1'b1;
    repeat (n) tick();
    pc_inc = 1'b0;
    m_pc   = m_pc + PC_W'(n);
  endtask

  task automatic set_pc(input logic [PC_W-1:0] target);
    int d;
    for (int it = 0; it < 8; it++) begin
      d = int'(target) - int'(m_pc) - 1;
      d = ((d % PC_MOD) + PC_MOD) % PC_MOD;
      if (d >= PC_MOD / 2) d -= PC_MOD;
      if (d >= -128 && d <= 127) begin
        branch(3'd0, d[7:0], 0, 3'd0);
        break;
      end
      branch(3'd0, 8'h7F, 0, 3'd0);
    end
    check("set_pc", pc, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PC_W-1:0] saved_pc;
    logic            saw_done;
    logic            t2;
    logic [PC_W-1:0] np2;

    rst_n         = 1'b0;
    status_load   = 1'b0;
    Z_in          = 3'b000;
    pc_inc        = 1'b0;
    bus.req_valid = 1'b0;
    bus.cond      = 3'b000;
    bus.imm8      = 8'h00;
    m_pc          = '0;
    m_status      = 3'b000;
    repeat (2) tick();
    check("rst_pc", pc, 0);
    check("rst_status", status, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_taken", bus.taken, 0);
    rst_n = 1'b1;
    tick();

    do_inc(3);
    tick();
    check("inc_pc", pc, 3);
    check("inc_status", status, 0);
    check("inc_ready", bus.req_ready, 1);

    do_load(3'b001);
    do_inc(7);
    branch(3'd1, 8'h05, 0, 3'd0);
    set_pc(9'd10);
    branch(3'd2, 8'h05, 0, 3'd0);

    do_load(3'b110);
    set_pc(9'd20);
    branch(3'd3, 8'h00, 0, 3'd0);
    do_load(3'b010);
    branch(3'd4, 8'hFC, 0, 3'd0);

    do_load(3'b000);
    set_pc(9'd0);
    branch(3'd1, 8'h02, 1, 3'b001);
    do_load(3'b000);
    set_pc(9'd0);
    branch(3'd1, 8'h02, 2, 3'b001);
    check("hazard_status", status, 3'b001);

    set_pc(9'd500);
    branch(3'd0, 8'h7F, 0, 3'd0);
    set_pc(9'd5);
    branch(3'd0, 8'h80, 0, 3'd0);

    branch(3'b111, 8'h05, 0, 3'd0);
    branch(3'b101, 8'h05, 0, 3'd0);

    // request held through EVAL/WRITE must wait for the next IDLE edge
    accept_req(3'd0, 8'h03, 0, 3'd0);
    bus.req_valid = 1'b1;
    bus.cond      = 3'd1;
    bus.imm8      = 8'h02;
    tick();
    check("held_ready_eval", bus.req_ready, 0);
    wait_done(1, 1'b0);
    check("held_ready_idle", bus.req_ready, 1);
    t2  = m_taken(3'd1, m_status);
    np2 = m_next(t2, 8'h02, m_pc);
    sb_q.push_back({t2, np2});
    m_pc = np2;
    tick();
    bus.req_valid = 1'b0;
    check("held_accepted", bus.req_ready, 0);
    wait_done(2, 1'b1);

    saved_pc = m_pc;
    accept_req(3'd0, 8'h10, 0, 3'd0);
    void'(sb_q.pop_back());
    m_pc = saved_pc;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 0);
    check("midrst_status", status, 0);
    check("midrst_ready", bus.req_ready, 1);
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    rst_n    = 1'b1;
    m_pc     = '0;
    m_status = 3'b000;
    repeat (3) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    branch(3'd0, 8'h04, 0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
